// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The state encoding is exported so the FSM can be observed from outside.
package fetch_pkg;

  localparam int          PC_W   = 32;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  // Compare in 33 bits so that a full 4 GiB ROM size does not overflow the limit.
  function automatic logic pc_in_range(input logic [PC_W-1:0] pc, input int words);
    return {1'b0, pc} < (33'(words) << 2);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} pairs with a combinational head.
// Flush wins over push and pop; the caller never pushes into a full queue without popping.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [PC_W-1:0] push_pc,
  input  logic [31:0]     push_instr,
  output logic            head_valid,
  output logic [PC_W-1:0] head_pc,
  output logic [31:0]     head_instr,
  output logic [CW-1:0]   count
);

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  assign head_valid = (count != '0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : NOP;
  assign head_instr = head_valid ? instr_mem[rd_ptr] : NOP;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: drives the ROM address, queues {pc, instr} pairs for IF/ID,
// and handles redirects plus out-of-range / misaligned fault capture.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          IMEM_WORDS  = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_en,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_instr,
  output logic         if_valid,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_instr,
  input  logic         if_ready,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fetch_fault,
  output logic [31:0]  fault_pc,
  output logic [2:0]   q_count,
  output fetch_state_t dbg_state
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  // Handshake: a head entry transfers on a rising edge where if_valid && if_ready;
  // if_valid never depends on if_ready, and a redirect flushes after honouring that transfer.

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n;
  logic [PC_W-1:0] fault_pc_n;
  logic            push, pop, flush;
  logic            redirect_bad;
  logic [CW-1:0]   count;

  assign pop          = if_valid && if_ready;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || !pc_in_range(redirect_pc, IMEM_WORDS);
  assign imem_addr    = fetch_pc;
  assign fetch_fault  = (state == ST_FAULT);
  assign q_count      = 3'(count);
  assign dbg_state    = state;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    fault_pc_n = fault_pc;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush      = 1'b1;
      fetch_pc_n = redirect_pc;
      if (redirect_bad) begin
        state_n    = ST_FAULT;
        fault_pc_n = redirect_pc;
      end else begin
        state_n = fetch_en ? ST_RUN : ST_IDLE;
      end
    end else begin
      case (state)
        ST_IDLE: if (fetch_en) state_n = ST_RUN;
        ST_RUN: begin
          // The range check runs before any push, so a wrapped PC is never fetched.
          if (!pc_in_range(fetch_pc, IMEM_WORDS)) begin
            state_n    = ST_FAULT;
            fault_pc_n = fetch_pc;
          end else if (!fetch_en) begin
            state_n = ST_IDLE;
          end else if (count < CW'(QUEUE_DEPTH) || pop) begin
            push       = 1'b1;
            fetch_pc_n = fetch_pc + PC_INC;
          end
        end
        default: state_n = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      fault_pc <= NOP;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      fault_pc <= fault_pc_n;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_pc    (fetch_pc),
    .push_instr (imem_instr),
    .head_valid (if_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .count      (count)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a small ROM stub and hand-computed expectations.
module tb_imem_fetch_ctrl;
  import fetch_pkg::*;

  logic         clk;
  logic         reset;
  logic         fetch_en;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_instr;
  logic         if_valid;
  logic [31:0]  if_pc;
  logic [31:0]  if_instr;
  logic         if_ready;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         fetch_fault;
  logic [31:0]  fault_pc;
  logic [2:0]   q_count;
  fetch_state_t dbg_state;

  int n_tests;
  int n_fail;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .q_count        (q_count),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM stub: three known words, every other word tagged with its index
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [7:0] idx;
    idx = addr[9:2];
    case (idx)
      8'h00:   return 32'h2004_0003;
      8'h01:   return 32'h2084_0001;
      8'h0B:   return 32'h0102_4020;
      default: return 32'hA500_0000 | {24'h0, idx};
    endcase
  endfunction

  always_comb imem_instr = rom_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    fetch_en       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_pc"}, if_pc, 32'h0);
    check({tag, "_instr"}, if_instr, 32'h0);
    check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    check({tag, "_fault_pc"}, fault_pc, 32'h0);
    check({tag, "_qcount"}, 32'(q_count), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // 1: reset values, latency, 1 instr/cycle
    do_reset();
    check_reset_values("rst");
    fetch_en = 1'b1;
    if_ready = 1'b1;
    step();
    check("t1_e1_valid", 32'(if_valid), 32'd0);
    check("t1_e1_state", 32'(dbg_state), 32'(ST_RUN));
    step();
    check("t1_e2_valid", 32'(if_valid), 32'd1);
    check("t1_e2_pc", if_pc, 32'h0);
    check("t1_e2_instr", if_instr, 32'h2004_0003);
    step();
    check("t1_e3_pc", if_pc, 32'h4);
    check("t1_e3_instr", if_instr, 32'h2084_0001);
    check("t1_e3_qcount", 32'(q_count), 32'd1);
    step();
    check("t1_e4_pc", if_pc, 32'h8);

    // 2: back-pressure saturates the queue, then in-order drain
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t2_full_qcount", 32'(q_count), 32'd4);
    check("t2_full_addr", imem_addr, 32'h10);
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain_pc%0d", i), if_pc, 32'(i * 4));
      check($sformatf("t2_drain_cnt%0d", i), 32'(q_count), 32'd4);
      step();
    end

    // 3: redirect on a full queue with a simultaneous pop
    check("t3_pre_qcount", 32'(q_count), 32'd4);
    check("t3_pre_pc", if_pc, 32'h10);
    redirect_to(32'h2C);
    check("t3_flush_valid", 32'(if_valid), 32'd0);
    check("t3_flush_qcount", 32'(q_count), 32'd0);
    check("t3_flush_addr", imem_addr, 32'h2C);
    step();
    check("t3_tgt_valid", 32'(if_valid), 32'd1);
    check("t3_tgt_pc", if_pc, 32'h2C);
    check("t3_tgt_instr", if_instr, 32'h0102_4020);

    // 4: run off the end of the ROM, then recover with a good redirect
    if_ready = 1'b0;
    redirect_to(32'h3FC);
    check("t4_redir_qcount", 32'(q_count), 32'd0);
    step();
    check("t4_last_pc", if_pc, 32'h3FC);
    check("t4_last_qcount", 32'(q_count), 32'd1);
    check("t4_last_fault", 32'(fetch_fault), 32'd0);
    step();
    check("t4_fault", 32'(fetch_fault), 32'd1);
    check("t4_fault_pc", fault_pc, 32'h400);
    check("t4_fault_state", 32'(dbg_state), 32'(ST_FAULT));
    step();
    check("t4_nopush_qcount", 32'(q_count), 32'd1);
    check("t4_drain_pc", if_pc, 32'h3FC);
    if_ready = 1'b1;
    redirect_to(32'h0);
    check("t4_recover_fault", 32'(fetch_fault), 32'd0);
    check("t4_recover_qcount", 32'(q_count), 32'd0);
    step();
    check("t4_refetch_pc", if_pc, 32'h0);
    check("t4_refetch_instr", if_instr, 32'h2004_0003);

    // 5: misaligned redirect faults, then an asynchronous reset mid-run
    if_ready = 1'b0;
    redirect_to(32'h6);
    check("t5_fault", 32'(fetch_fault), 32'd1);
    check("t5_fault_pc", fault_pc, 32'h6);
    check("t5_qcount", 32'(q_count), 32'd0);
    step();
    step();
    check("t5_nopush_qcount", 32'(q_count), 32'd0);
    check("t5_nopush_valid", 32'(if_valid), 32'd0);
    redirect_to(32'h0);
    step();
    step();
    check("t5_run_qcount", 32'(q_count), 32'd2);
    #2 reset = 1'b0;
    #1 check_reset_values("t5_async");
    do_reset();

    // 6: drop fetch_en with three entries queued
    fetch_en = 1'b1;
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t6_qcount", 32'(q_count), 32'd3);
    fetch_en = 1'b0;
    step();
    check("t6_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_idle_qcount", 32'(q_count), 32'd3);
    check("t6_idle_addr", imem_addr, 32'hC);
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_drain_pc%0d", i), if_pc, 32'(i * 4));
      check($sformatf("t6_drain_cnt%0d", i), 32'(q_count), 32'(3 - i));
      step();
    end
    check("t6_empty_valid", 32'(if_valid), 32'd0);
    check("t6_empty_qcount", 32'(q_count), 32'd0);
    step();
    check("t6_frozen_addr", imem_addr, 32'hC);
    check("t6_still_empty", 32'(q_count), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
